// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: parity codes, TX FSM encoding, frame length helper
//   Contents: PAR_NONE/PAR_EVEN/PAR_ODD, tx_state_e, frame_bits()
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit periods in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host/line bundle for the queued UART transmitter
//   trmt, tx_data              host push strobe and word
//   TX, tx_done, busy          serial line and frame status
//   fifo_full, fifo_empty, ovf queue status and dropped-push pulse
//   master: host side; slave: transmitter side
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 trmt;
  logic [DATA_BITS-1:0] tx_data;
  logic                 TX;
  logic                 tx_done;
  logic                 busy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 ovf;

  modport master (
    output trmt, tx_data,
    input  TX, tx_done, busy, fifo_full, fifo_empty, ovf
  );

  modport slave (
    input  trmt, tx_data,
    output TX, tx_done, busy, fifo_full, fifo_empty, ovf
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty/ovf flags
//   clk, rst     clock, asynchronous active-high reset
//   push, wdata  write request and word; accepted if not full or popping this cycle
//   pop, rdata   read request (ignored when empty) and head word (combinational)
//   full, empty  registered level flags
//   ovf          one-clock pulse after a push was dropped
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot a same-cycle push needs, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count_n = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
      ovf   <= push & ~do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - queued UART transmitter with configurable width, parity, stop bits and baud
//   clk, rst   system clock, asynchronous active-high reset
//   bus        uart_tx_fifo_if.slave: trmt/tx_data in; TX, tx_done, busy,
//              fifo_full, fifo_empty, ovf out (all registered)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int BAUD_DIV  = 2604,
  parameter int DEPTH     = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  tx_state_e            state, state_n;
  logic [CW-1:0]        baud_cnt, baud_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 par_q, par_n;
  logic                 tx_q, tx_n;
  logic                 done_q, done_n;
  logic                 busy_q, busy_n;
  logic                 tick;
  logic                 load;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_ovf;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.trmt),
    .pop   (pop),
    .wdata (bus.tx_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  assign tick     = (baud_cnt == BAUD_LAST);
  assign head_par = (PARITY == PAR_ODD) ? ~^head : ^head;

  // Next-state logic. tx_n is the line level for the bit that starts on the
  // coming edge, so TX stays a plain register with no path from the host inputs.
  always_comb begin
    state_n = state;
    baud_n  = tick ? '0 : baud_cnt + CW'(1);
    bit_n   = bit_idx;
    sh_n    = shreg;
    par_n   = par_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    busy_n  = busy_q;
    pop     = 1'b0;
    load    = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        baud_n = '0;
        load   = ~fifo_empty;
      end
      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx == DATA_LAST) begin
            bit_n = '0;
            if (HAS_PAR) begin
              state_n = ST_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = ST_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_idx + BW'(1);
            sh_n  = shreg >> 1;
            tx_n  = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_n = ST_STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_idx == STOP_LAST) begin
            done_n = 1'b1;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_n = ST_IDLE;
              tx_n    = 1'b1;
              busy_n  = 1'b0;
            end
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // Frame launch from IDLE or straight out of the last stop bit.
    if (load) begin
      pop     = 1'b1;
      sh_n    = head;
      par_n   = head_par;
      state_n = ST_START;
      baud_n  = '0;
      tx_n    = 1'b0;
      busy_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shreg    <= sh_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.TX         = tx_q;
  assign bus.tx_done    = done_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.ovf        = fifo_ovf;

endmodule
